// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide sequencer owning the HI/LO result pair.
// MULT is a radix-2 Booth loop; DIV is restoring division on magnitudes
// with a final sign correction. Both take WIDTH single-step iterations.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_count;
  // MULT: Booth accumulator high half (one guard bit so A-M cannot overflow
  // when M is the most negative value). DIV: partial remainder.
  logic [WIDTH:0]   r_acc_hi;
  // MULT: multiplier / low product half. DIV: dividend magnitude / quotient.
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_q_m1;
  // MULT: multiplicand. DIV: divisor magnitude.
  logic [WIDTH-1:0] r_mcand;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_last;
  logic             w_accept;
  logic             w_zero_div;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH:0]   w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_div_hi_fix;
  logic [WIDTH-1:0] w_div_lo_fix;

  assign w_last     = (r_count == CW'(WIDTH - 1));
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_zero_div = op && (src_b == '0);
  assign w_abs_a    = src_a[WIDTH-1] ? (~src_a + 1'b1) : src_a;
  assign w_abs_b    = src_b[WIDTH-1] ? (~src_b + 1'b1) : src_b;

  // Next-state logic for the operation sequencer
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!op)             w_state_next = S_MULT;
          else if (w_zero_div) w_state_next = S_DONE;
          else                 w_state_next = S_DIV;
        end
      end
      S_MULT:  if (w_last) w_state_next = S_DONE;
      S_DIV:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // One Booth step: add/subtract per {q0, q-1}, then arithmetic shift right
  always_comb begin
    w_m_ext = {r_mcand[WIDTH-1], r_mcand};
    case ({r_acc_lo[0], r_q_m1})
      2'b01:   w_booth_sum = r_acc_hi + w_m_ext;
      2'b10:   w_booth_sum = r_acc_hi - w_m_ext;
      default: w_booth_sum = r_acc_hi;
    endcase
    w_mul_hi = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
    w_mul_lo = {w_booth_sum[0], r_acc_lo[WIDTH-1:1]};
  end

  // One restoring-division step plus the final sign correction
  always_comb begin
    w_div_shift  = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
    w_div_ge     = (w_div_shift >= {1'b0, r_mcand});
    w_div_rem    = w_div_ge ? (w_div_shift - {1'b0, r_mcand}) : w_div_shift;
    w_div_quo    = {r_acc_lo[WIDTH-2:0], w_div_ge};
    w_div_lo_fix = r_neg_q ? (~w_div_quo + 1'b1) : w_div_quo;
    w_div_hi_fix = r_neg_r ? (~w_div_rem[WIDTH-1:0] + 1'b1) : w_div_rem[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_q_m1   <= 1'b0;
      r_mcand  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_accept) begin
      r_count  <= '0;
      r_acc_hi <= '0;
      r_q_m1   <= 1'b0;
      r_acc_lo <= op ? w_abs_a : src_b;
      r_mcand  <= op ? w_abs_b : src_a;
      r_neg_q  <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
      r_neg_r  <= src_a[WIDTH-1];
    end else if (r_state == S_MULT) begin
      r_count  <= r_count + CW'(1);
      r_acc_hi <= w_mul_hi;
      r_acc_lo <= w_mul_lo;
      r_q_m1   <= r_acc_lo[0];
    end else if (r_state == S_DIV) begin
      r_count  <= r_count + CW'(1);
      r_acc_hi <= w_div_rem;
      r_acc_lo <= w_div_quo;
    end
  end

  // HI/LO load on the final iteration edge; a divide-by-zero leaves them alone
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_MULT && w_last) begin
      r_hi <= w_mul_hi[WIDTH-1:0];
      r_lo <= w_mul_lo;
    end else if (r_state == S_DIV && w_last) begin
      r_hi <= w_div_hi_fix;
      r_lo <= w_div_lo_fix;
    end
  end

  // Registered status flags derived from the upcoming state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= (w_state_next == S_DONE);
      r_div_zero <= w_accept && w_zero_div;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: directed cases plus randomized
// back-to-back operations checked against plain signed arithmetic.
module tb_mult_div_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_checks;
  int n_errors;

  mult_div_seq #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: full signed product as {hi, lo}
  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  // Reference: truncating division, remainder sign follows dividend, as {rem, quo}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return {32'(pa % pb), 32'(pa / pb)};
  endfunction

  // Issue one operation and wait for done; lat = edges after the start edge
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic dz);
    int guard;
    guard = 0;
    while (busy && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    @(negedge clock);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clock); #1;
    start = 1'b0; op = 1'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    dz = div_zero;
  endtask

  task automatic test_reset;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %0b want 0", done); end
    n_checks++; if (div_zero !== 1'b0) begin n_errors++; $display("FAIL reset_div_zero got %0b want 0", div_zero); end
    n_checks++; if (hi_out !== 32'h0) begin n_errors++; $display("FAIL reset_hi got %h want 0", hi_out); end
    n_checks++; if (lo_out !== 32'h0) begin n_errors++; $display("FAIL reset_lo got %h want 0", lo_out); end
    $display("reset: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi_out, lo_out);
  endtask

  task automatic test_mult;
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [63:0] exp_p [3];
    int lat;
    logic dz;
    ta[0] = 32'h0000_0007; tb[0] = 32'hFFFF_FFFD; exp_p[0] = 64'hFFFF_FFFF_FFFF_FFEB;
    ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000; exp_p[1] = 64'h4000_0000_0000_0000;
    ta[2] = 32'h7FFF_FFFF; tb[2] = 32'h7FFF_FFFF; exp_p[2] = 64'h3FFF_FFFF_0000_0001;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, ta[i], tb[i], lat, dz);
      $display("mult %h * %h -> hi=%h lo=%h lat=%0d", ta[i], tb[i], hi_out, lo_out, lat);
      n_checks++; if (lat !== 32) begin n_errors++; $display("FAIL mult_latency got %0d want 32", lat); end
      n_checks++; if (hi_out !== exp_p[i][63:32]) begin n_errors++; $display("FAIL mult_hi got %h want %h", hi_out, exp_p[i][63:32]); end
      n_checks++; if (lo_out !== exp_p[i][31:0]) begin n_errors++; $display("FAIL mult_lo got %h want %h", lo_out, exp_p[i][31:0]); end
      n_checks++; if (dz !== 1'b0) begin n_errors++; $display("FAIL mult_div_zero got %0b want 0", dz); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL mult_busy_in_done got %0b want 1", busy); end
      @(posedge clock); #1;
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL mult_after_done got done=%0b busy=%0b want 0 0", done, busy); end
    end
  endtask

  task automatic test_div;
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [31:0] eq [3];
    logic [31:0] er [3];
    int lat;
    logic dz;
    ta[0] = 32'hFFFF_FFF9; tb[0] = 32'h0000_0002; eq[0] = 32'hFFFF_FFFD; er[0] = 32'hFFFF_FFFF;
    ta[1] = 32'h0000_0007; tb[1] = 32'hFFFF_FFFE; eq[1] = 32'hFFFF_FFFD; er[1] = 32'h0000_0001;
    ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF; eq[2] = 32'h8000_0000; er[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, ta[i], tb[i], lat, dz);
      $display("div %h / %h -> hi=%h lo=%h lat=%0d", ta[i], tb[i], hi_out, lo_out, lat);
      n_checks++; if (lat !== 32) begin n_errors++; $display("FAIL div_latency got %0d want 32", lat); end
      n_checks++; if (lo_out !== eq[i]) begin n_errors++; $display("FAIL div_quotient got %h want %h", lo_out, eq[i]); end
      n_checks++; if (hi_out !== er[i]) begin n_errors++; $display("FAIL div_remainder got %h want %h", hi_out, er[i]); end
      n_checks++; if (dz !== 1'b0) begin n_errors++; $display("FAIL div_div_zero got %0b want 0", dz); end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic dz;
    // 0x451 / 0x20 leaves hi=0x11, lo=0x22 as the prior result
    do_op(1'b1, 32'h0000_0451, 32'h0000_0020, lat, dz);
    n_checks++; if (hi_out !== 32'h11 || lo_out !== 32'h22) begin n_errors++; $display("FAIL dz_setup got %h/%h want 11/22", hi_out, lo_out); end
    do_op(1'b1, 32'h0000_0005, 32'h0000_0000, lat, dz);
    $display("div 5 / 0 -> done_lat=%0d div_zero=%0b hi=%h lo=%h", lat, dz, hi_out, lo_out);
    n_checks++; if (lat !== 0) begin n_errors++; $display("FAIL dz_latency got %0d want 0", lat); end
    n_checks++; if (dz !== 1'b1) begin n_errors++; $display("FAIL dz_flag got %0b want 1", dz); end
    n_checks++; if (hi_out !== 32'h11) begin n_errors++; $display("FAIL dz_hi_hold got %h want 11", hi_out); end
    n_checks++; if (lo_out !== 32'h22) begin n_errors++; $display("FAIL dz_lo_hold got %h want 22", lo_out); end
    @(posedge clock); #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      n_errors++; $display("FAIL dz_after got busy=%0b done=%0b dz=%0b want 0 0 0", busy, done, div_zero);
    end
  endtask

  task automatic test_start_while_busy;
    int n_done;
    int done_edge;
    @(negedge clock);
    start = 1'b1; op = 1'b0; src_a = 32'd3; src_b = 32'd4;
    @(posedge clock); #1;
    start = 1'b0;
    n_done = 0; done_edge = -1;
    for (int e = 1; e <= 45; e++) begin
      @(negedge clock);
      if (e == 5 || e == 32) begin start = 1'b1; op = 1'b1; src_a = 32'd9; src_b = 32'd3; end
      else start = 1'b0;
      @(posedge clock); #1;
      if (done) begin n_done++; done_edge = e; end
    end
    start = 1'b0;
    $display("start_while_busy: dones=%0d at edge %0d hi=%h lo=%h", n_done, done_edge, hi_out, lo_out);
    n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL swb_done_count got %0d want 1", n_done); end
    n_checks++; if (done_edge !== 32) begin n_errors++; $display("FAIL swb_done_edge got %0d want 32", done_edge); end
    n_checks++; if (lo_out !== 32'h0000_000C) begin n_errors++; $display("FAIL swb_lo got %h want 0000000c", lo_out); end
    n_checks++; if (hi_out !== 32'h0) begin n_errors++; $display("FAIL swb_hi got %h want 0", hi_out); end
  endtask

  task automatic test_reset_mid;
    int n_done;
    int lat;
    logic dz;
    @(negedge clock);
    start = 1'b1; op = 1'b1; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    $display("reset_mid: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi_out, lo_out);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rmid_done got %0b want 0", done); end
    n_checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin n_errors++; $display("FAIL rmid_result got %h/%h want 0/0", hi_out, lo_out); end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    n_done = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock); #1;
      if (done || busy) n_done++;
    end
    n_checks++; if (n_done !== 0) begin n_errors++; $display("FAIL rmid_ghost_done got %0d active cycles want 0", n_done); end
    do_op(1'b0, 32'd2, 32'd2, lat, dz);
    n_checks++; if (lo_out !== 32'd4 || hi_out !== 32'd0) begin n_errors++; $display("FAIL rmid_new_mult got %h/%h want 0/4", hi_out, lo_out); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Randomized ops issued in the cycle busy falls, with HI/LO tracked by the model
  task automatic test_back_to_back;
    logic [31:0] a, b, exp_hi, exp_lo;
    logic [63:0] r;
    logic o, dz, exp_dz;
    int lat, exp_lat;
    exp_hi = hi_out;
    exp_lo = lo_out;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom);
      a = pick_operand();
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : pick_operand();
      exp_dz = 1'b0; exp_lat = 32;
      if (!o) begin
        r = ref_mult(a, b); exp_hi = r[63:32]; exp_lo = r[31:0];
      end else if (b == 32'h0) begin
        exp_dz = 1'b1; exp_lat = 0;
      end else begin
        r = ref_div(a, b); exp_hi = r[63:32]; exp_lo = r[31:0];
      end
      do_op(o, a, b, lat, dz);
      $display("b2b %0d op=%0b a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d", i, o, a, b, hi_out, lo_out, dz, lat);
      n_checks++; if (lat !== exp_lat) begin n_errors++; $display("FAIL b2b_latency got %0d want %0d", lat, exp_lat); end
      n_checks++; if (dz !== exp_dz) begin n_errors++; $display("FAIL b2b_div_zero got %0b want %0b", dz, exp_dz); end
      n_checks++; if (hi_out !== exp_hi) begin n_errors++; $display("FAIL b2b_hi got %h want %h", hi_out, exp_hi); end
      n_checks++; if (lo_out !== exp_lo) begin n_errors++; $display("FAIL b2b_lo got %h want %h", lo_out, exp_lo); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clock);
    #1;
    test_reset;
    @(negedge clock);
    reset = 1'b1;
    test_mult;
    test_div;
    test_div_zero;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
